// File: rtl/rename_multi.sv
// N-wide register rename: accepts the in-order prefix of a decoded group that fits
// ROB/IQ/LSQ/free-list space, bypasses intra-group producers and registers dispatch.
module rename_multi #(
    parameter int WIDTH    = 2,
    parameter int LOG_ARCH = 5,
    parameter int NUM_ARCH = 32,
    parameter int LOG_PHYS = 6,
    parameter int CNT_W    = 3
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         Flush,
    input  logic [WIDTH-1:0]             In_valid,
    input  logic [WIDTH*LOG_ARCH-1:0]    In_src_a,
    input  logic [WIDTH*LOG_ARCH-1:0]    In_src_b,
    input  logic [WIDTH*LOG_ARCH-1:0]    In_dst,
    input  logic [WIDTH-1:0]             In_regwrite,
    input  logic [WIDTH-1:0]             In_memread,
    input  logic [WIDTH-1:0]             In_memwrite,
    input  logic [NUM_ARCH*LOG_PHYS-1:0] Map_arch_to_phys,
    input  logic [NUM_ARCH-1:0]          Busy_list,
    input  logic [WIDTH*LOG_PHYS-1:0]    Free_phys_regs,
    input  logic [CNT_W-1:0]             Free_count,
    input  logic [CNT_W-1:0]             Rob_free,
    input  logic [CNT_W-1:0]             Iq_free,
    input  logic [CNT_W-1:0]             Lsq_free,
    output logic [CNT_W-1:0]             Pop_count,
    output logic [CNT_W-1:0]             Freelist_pop_count,
    output logic [WIDTH-1:0]             Frat_we,
    output logic [WIDTH*LOG_ARCH-1:0]    Frat_arch,
    output logic [WIDTH*LOG_PHYS-1:0]    Frat_phys,
    output logic [WIDTH-1:0]             Out_valid,
    output logic [WIDTH*LOG_PHYS-1:0]    Out_src_a_phys,
    output logic [WIDTH*LOG_PHYS-1:0]    Out_src_b_phys,
    output logic [WIDTH-1:0]             Out_src_a_rdy,
    output logic [WIDTH-1:0]             Out_src_b_rdy,
    output logic [WIDTH*LOG_PHYS-1:0]    Out_dst_phys,
    output logic [WIDTH-1:0]             Out_dst_alloc,
    output logic [WIDTH-1:0]             Out_to_lsq,
    output logic [15:0]                  Stall_cycles
);
    // One extra bit so running totals never wrap before comparison.
    localparam int CW = CNT_W + 1;

    logic [CW-1:0]       rob_n, lsq_n, phys_n, n_valid;
    logic                go, alloc_need, mem_need;
    logic [LOG_ARCH-1:0] s_a, s_b;
    logic [LOG_ARCH-1:0] dst_c  [WIDTH];
    logic [LOG_PHYS-1:0] newp_c [WIDTH];
    logic [WIDTH-1:0]    acc_c, alloc_c;

    logic [WIDTH-1:0]          valid_d, ra_d, rb_d, alloc_d, lsq_d;
    logic [WIDTH*LOG_PHYS-1:0] sa_d, sb_d, dst_d;
    logic [WIDTH-1:0]          valid_q, ra_q, rb_q, alloc_q, lsq_q;
    logic [WIDTH*LOG_PHYS-1:0] sa_q, sb_q, dst_q;
    logic [15:0]               stall_d, stall_q;

    always_comb begin
        rob_n   = '0;
        lsq_n   = '0;
        phys_n  = '0;
        go      = !RESET && !Flush;
        acc_c   = '0;
        alloc_c = '0;
        valid_d = '0;
        ra_d    = '0;
        rb_d    = '0;
        alloc_d = '0;
        lsq_d   = '0;
        sa_d    = '0;
        sb_d    = '0;
        dst_d   = '0;
        alloc_need = 1'b0;
        mem_need   = 1'b0;
        s_a        = '0;
        s_b        = '0;
        for (int k = 0; k < WIDTH; k++) begin
            dst_c[k]  = In_dst[k*LOG_ARCH +: LOG_ARCH];
            newp_c[k] = '0;
        end
        for (int k = 0; k < WIDTH; k++) begin
            s_a        = In_src_a[k*LOG_ARCH +: LOG_ARCH];
            s_b        = In_src_b[k*LOG_ARCH +: LOG_ARCH];
            alloc_need = In_regwrite[k] && (dst_c[k] != '0);
            mem_need   = In_memread[k] || In_memwrite[k];
            if (go && In_valid[k]
                && (rob_n + CW'(1) <= {1'b0, Rob_free})
                && (rob_n + CW'(1) <= {1'b0, Iq_free})
                && (phys_n + CW'(alloc_need) <= {1'b0, Free_count})
                && (lsq_n + CW'(mem_need) <= {1'b0, Lsq_free})) begin
                acc_c[k]   = 1'b1;
                alloc_c[k] = alloc_need;
                if (alloc_need)
                    newp_c[k] = Free_phys_regs[int'(phys_n)*LOG_PHYS +: LOG_PHYS];
                valid_d[k] = 1'b1;
                alloc_d[k] = alloc_need;
                lsq_d[k]   = mem_need;
                dst_d[k*LOG_PHYS +: LOG_PHYS] = newp_c[k];
                if (s_a != '0) begin
                    sa_d[k*LOG_PHYS +: LOG_PHYS] = Map_arch_to_phys[int'(s_a)*LOG_PHYS +: LOG_PHYS];
                    ra_d[k] = !Busy_list[s_a];
                end else begin
                    ra_d[k] = 1'b1;
                end
                if (s_b != '0) begin
                    sb_d[k*LOG_PHYS +: LOG_PHYS] = Map_arch_to_phys[int'(s_b)*LOG_PHYS +: LOG_PHYS];
                    rb_d[k] = !Busy_list[s_b];
                end else begin
                    rb_d[k] = 1'b1;
                end
                // Later producers overwrite earlier ones, leaving the nearest in the group.
                for (int j = 0; j < k; j++) begin
                    if (alloc_c[j] && dst_c[j] == s_a) begin
                        sa_d[k*LOG_PHYS +: LOG_PHYS] = newp_c[j];
                        ra_d[k] = 1'b0;
                    end
                    if (alloc_c[j] && dst_c[j] == s_b) begin
                        sb_d[k*LOG_PHYS +: LOG_PHYS] = newp_c[j];
                        rb_d[k] = 1'b0;
                    end
                end
                rob_n  = rob_n + CW'(1);
                phys_n = phys_n + CW'(alloc_need);
                lsq_n  = lsq_n + CW'(mem_need);
            end else begin
                go = 1'b0;
            end
        end
    end

    // Only the youngest writer of an arch reg in the group updates the F-RAT.
    always_comb begin
        Frat_we   = '0;
        Frat_arch = '0;
        Frat_phys = '0;
        for (int k = 0; k < WIDTH; k++) begin
            Frat_we[k] = alloc_c[k];
            for (int j = k + 1; j < WIDTH; j++) begin
                if (alloc_c[j] && dst_c[j] == dst_c[k])
                    Frat_we[k] = 1'b0;
            end
            if (Frat_we[k]) begin
                Frat_arch[k*LOG_ARCH +: LOG_ARCH] = dst_c[k];
                Frat_phys[k*LOG_PHYS +: LOG_PHYS] = newp_c[k];
            end
        end
    end

    assign Pop_count          = rob_n[CNT_W-1:0];
    assign Freelist_pop_count = phys_n[CNT_W-1:0];

    always_comb begin
        n_valid = '0;
        for (int k = 0; k < WIDTH; k++)
            n_valid = n_valid + CW'(In_valid[k]);
        stall_d = stall_q;
        if (!Flush && In_valid[0] && (rob_n < n_valid) && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            alloc_q <= '0;
            lsq_q   <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            dst_q   <= '0;
            stall_q <= '0;
        end else begin
            valid_q <= valid_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            alloc_q <= alloc_d;
            lsq_q   <= lsq_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dst_q   <= dst_d;
            stall_q <= stall_d;
        end
    end

    assign Out_valid      = valid_q;
    assign Out_src_a_phys = sa_q;
    assign Out_src_b_phys = sb_q;
    assign Out_src_a_rdy  = ra_q;
    assign Out_src_b_rdy  = rb_q;
    assign Out_dst_phys   = dst_q;
    assign Out_dst_alloc  = alloc_q;
    assign Out_to_lsq     = lsq_q;
    assign Stall_cycles   = stall_q;
endmodule
